// File: rtl/icache_dm_2word.sv
// icache_dm_2word: direct-mapped instruction cache with 2-word (8-byte) lines.
// A lookup hit returns the selected word combinationally in the same cycle.
// A miss stalls fetch. It reads one 64-bit block from main memory over a fixed
// latency, writes that block into the indexed line, and then replays the lookup.
module icache_dm_2word #(
    parameter int NUM_LINES    = 8,
    parameter int MISS_LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC,
    input  logic        Req,
    output logic [31:0] Inst,
    output logic        Stall,
    output logic        Access_MM,
    output logic [31:0] PC_MM,
    input  logic [63:0] Data_MM,
    output logic [31:0] Hit_Count,
    output logic [31:0] Miss_Count
);

    localparam int IDX = $clog2(NUM_LINES);
    localparam int TW  = 29 - IDX;
    localparam int CW  = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(MISS_LATENCY - 1);

    typedef enum logic [1:0] {S_LOOKUP, S_FETCH, S_FILL} state_t;

    state_t          state_q, state_d;
    logic [28:0]     miss_blk_q, miss_blk_d;   // miss_pc[31:3]
    logic [CW-1:0]   lat_q, lat_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    // Line storage. Only the valid bits are reset. Tags and data are meaningless
    // until the valid bit of their line is set.
    logic            valid_q   [NUM_LINES];
    logic [TW-1:0]   tag_q     [NUM_LINES];
    logic [31:0]     data_hi_q [NUM_LINES];
    logic [31:0]     data_lo_q [NUM_LINES];

    logic [TW-1:0]   pc_tag;
    logic [IDX-1:0]  pc_idx;
    logic            pc_off;
    logic [TW-1:0]   miss_tag;
    logic [IDX-1:0]  miss_idx;
    logic            lookup_hit;
    logic            fill_en;
    logic            unused_pc_bits;

    assign pc_tag         = PC[31:3+IDX];
    assign pc_idx         = PC[3+IDX-1:3];
    assign pc_off         = PC[2];
    assign miss_tag       = miss_blk_q[28:IDX];
    assign miss_idx       = miss_blk_q[IDX-1:0];
    assign unused_pc_bits = ^PC[1:0];

    // The read is combinational so that a hit delivers in the same cycle.
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill_en    = (state_q == S_FETCH) && (lat_q == LAT_LAST);

    assign Hit_Count  = hit_cnt_q;
    assign Miss_Count = miss_cnt_q;

    // Per-line valid bits: cleared by reset and set when the refill completes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET)
                    valid_q[gi] <= 1'b0;
                else if (fill_en && (miss_idx == IDX'(gi)))
                    valid_q[gi] <= 1'b1;
            end
        end
    endgenerate

    // Tag and data write at the final FETCH edge. This is gated by state_q, so a
    // reset discards the write.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[miss_idx]     <= miss_tag;
            data_hi_q[miss_idx] <= Data_MM[63:32];
            data_lo_q[miss_idx] <= Data_MM[31:0];
        end
    end

    // State, miss address, latency counter and performance counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_LOOKUP;
            miss_blk_q <= '0;
            lat_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_blk_q <= miss_blk_d;
            lat_q      <= lat_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        miss_blk_d = miss_blk_q;
        lat_d      = lat_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        Inst       = 32'h0;
        Stall      = 1'b0;
        Access_MM  = 1'b0;
        PC_MM      = 32'h0;
        case (state_q)
            S_LOOKUP: begin
                if (Req) begin
                    if (lookup_hit) begin
                        Inst      = pc_off ? data_lo_q[pc_idx] : data_hi_q[pc_idx];
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end else begin
                        Stall      = 1'b1;
                        miss_blk_d = PC[31:3];
                        lat_d      = '0;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                Access_MM = 1'b1;
                PC_MM     = {miss_blk_q, 3'b000};
                Stall     = 1'b1;
                lat_d     = lat_q + 1'b1;
                if (fill_en)
                    state_d = S_FILL;
            end
            S_FILL: begin
                Stall   = 1'b1;
                state_d = S_LOOKUP;
            end
            default: state_d = S_LOOKUP;
        endcase
    end

endmodule

// File: tb/tb_icache_dm_2word.sv
// Directed testbench for icache_dm_2word (NUM_LINES=8, MISS_LATENCY=4).
// Inputs change right after a falling edge. Outputs are checked 1 ns later,
// which is inside the same cycle and well before the next rising edge.
module tb_icache_dm_2word;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC;
    logic        Req;
    logic [31:0] Inst;
    logic        Stall;
    logic        Access_MM;
    logic [31:0] PC_MM;
    logic [63:0] Data_MM;
    logic [31:0] Hit_Count;
    logic [31:0] Miss_Count;

    int total = 0;
    int bad   = 0;

    icache_dm_2word #(.NUM_LINES(8), .MISS_LATENCY(4)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .Req(Req), .Inst(Inst),
        .Stall(Stall), .Access_MM(Access_MM), .PC_MM(PC_MM),
        .Data_MM(Data_MM), .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
    );

    always #5 CLK = ~CLK;

    // Main memory contents: 0x0 -> 0xA, 0x4 -> 0xB, anything else -> D00D_<addr>.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hA;
        if (a == 32'h4) return 32'hB;
        return {16'hD00D, a[15:0]};
    endfunction

    always_comb Data_MM = {mem_word(PC_MM), mem_word(PC_MM + 32'd4)};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic req, input logic [31:0] pc);
        @(negedge CLK);
        Req = req;
        PC  = pc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        Req   = 1'b0;
        PC    = 32'h0;
        #1;
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_acc", {31'd0, Access_MM}, 32'd0);
        chk("rst_miss", Miss_Count, 32'd0);
        chk("rst_hit", Hit_Count, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Miss cycle, 4 FETCH cycles, 1 FILL cycle, all at the same PC.
    task automatic miss_seq(input logic [31:0] pc, input logic [31:0] blk);
        step(1'b1, pc);
        chk("miss_stall", {31'd0, Stall}, 32'd1);
        chk("miss_inst", Inst, 32'd0);
        chk("miss_acc", {31'd0, Access_MM}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pc);
            chk("fetch_acc", {31'd0, Access_MM}, 32'd1);
            chk("fetch_pcmm", PC_MM, blk);
            chk("fetch_stall", {31'd0, Stall}, 32'd1);
        end
        step(1'b1, pc);
        chk("fill_stall", {31'd0, Stall}, 32'd1);
        chk("fill_acc", {31'd0, Access_MM}, 32'd0);
        chk("fill_pcmm", PC_MM, 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        Req   = 1'b0;
        PC    = 32'h0;
        #1;
        chk("init_inst", Inst, 32'd0);
        chk("init_pcmm", PC_MM, 32'd0);
        do_reset();

        // 1: cold miss at 0x0, then the replay hits
        miss_seq(32'h0, 32'h0);
        step(1'b1, 32'h0);
        chk("s1_inst", Inst, 32'hA);
        chk("s1_stall", {31'd0, Stall}, 32'd0);
        chk("s1_miss", Miss_Count, 32'd1);
        // 2: same block, other word
        step(1'b1, 32'h4);
        chk("s2_inst", Inst, 32'hB);
        chk("s2_stall", {31'd0, Stall}, 32'd0);
        chk("s2_acc", {31'd0, Access_MM}, 32'd0);
        chk("s1_hit", Hit_Count, 32'd1);
        step(1'b0, 32'h0);
        chk("s2_hit", Hit_Count, 32'd2);
        chk("s2_miss", Miss_Count, 32'd1);

        // 3: conflict eviction on index 0
        do_reset();
        miss_seq(32'h0, 32'h0);
        step(1'b1, 32'h0);
        chk("s3_inst0", Inst, 32'hA);
        miss_seq(32'h40, 32'h40);
        step(1'b1, 32'h40);
        chk("s3_inst40", Inst, 32'hD00D0040);
        miss_seq(32'h0, 32'h0);
        step(1'b1, 32'h0);
        chk("s3_inst0b", Inst, 32'hA);
        chk("s3_miss", Miss_Count, 32'd3);

        // 4: reset during the 2nd FETCH cycle
        do_reset();
        step(1'b1, 32'h0);
        chk("s4_miss_stall", {31'd0, Stall}, 32'd1);
        step(1'b1, 32'h0);
        step(1'b1, 32'h0);
        chk("s4_fetch2_acc", {31'd0, Access_MM}, 32'd1);
        RESET = 1'b1;
        Req   = 1'b0;
        #1;
        chk("s4_acc_drop", {31'd0, Access_MM}, 32'd0);
        chk("s4_stall_drop", {31'd0, Stall}, 32'd0);
        chk("s4_miss_clr", Miss_Count, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        miss_seq(32'h0, 32'h0);
        step(1'b1, 32'h0);
        chk("s4_inst", Inst, 32'hA);
        chk("s4_miss", Miss_Count, 32'd1);

        // 5: PC moves to 0x8 during the stall
        do_reset();
        step(1'b1, 32'h0);
        chk("s5_miss_stall", {31'd0, Stall}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h8);
            chk("s5_pcmm0", PC_MM, 32'h0);
        end
        step(1'b1, 32'h8);
        chk("s5_fill_stall", {31'd0, Stall}, 32'd1);
        miss_seq(32'h8, 32'h8);
        step(1'b1, 32'h8);
        chk("s5_inst8", Inst, 32'hD00D0008);
        step(1'b1, 32'h0);
        chk("s5_inst0", Inst, 32'hA);
        chk("s5_stall0", {31'd0, Stall}, 32'd0);
        step(1'b1, 32'hC);
        chk("s5_instC", Inst, 32'hD00D000C);

        // 6: idle for 10 cycles, then a hit on preserved state
        for (int i = 0; i < 10; i++) begin
            step(1'b0, $urandom);
            chk("s6_inst", Inst, 32'd0);
            chk("s6_stall", {31'd0, Stall}, 32'd0);
            chk("s6_acc", {31'd0, Access_MM}, 32'd0);
            chk("s6_hit", Hit_Count, 32'd3);
            chk("s6_miss", Miss_Count, 32'd2);
        end
        step(1'b1, 32'h0);
        chk("s6_inst0", Inst, 32'hA);
        chk("s6_stall0", {31'd0, Stall}, 32'd0);
        step(1'b0, 32'h0);
        chk("s6_hit_end", Hit_Count, 32'd4);
        chk("s6_miss_end", Miss_Count, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm_2word.md
Name: icache_dm_2word

Overview:
- Direct-mapped instruction cache sitting between the fetch-stage PC register and the 64-bit two-word main memory.
- Each line holds one 2-word block (8 bytes), and PC[2] selects the word within the block.
- On a miss it stalls fetch, drives Access_MM and a block-aligned address for a fixed miss latency, captures Data_MM, then replays the lookup.
- It keeps hit and miss counters for performance measurement.

Parameters:
- NUM_LINES, 8: number of cache lines; power of 2, ≥2; IDX = log2(NUM_LINES).
- MISS_LATENCY, 4: cycles Access_MM is held per refill; ≥1.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  32  fetch byte address; PC[1:0] ignored.
- Req  in  1  fetch request valid.
- Inst  out  32  fetched instruction; 0 when not delivering.
- Stall  out  1  fetch must hold PC/Req this cycle.
- Access_MM  out  1  main-memory read enable.
- PC_MM  out  32  main-memory block address {miss_pc[31:3],3'b000}; 0 when Access_MM=0.
- Data_MM  in  64  memory block; [63:32] = word at block offset 0, [31:0] = word at offset 4.
- Hit_Count  out  32  number of hits since reset.
- Miss_Count  out  32  number of misses since reset.

Behaviour:
- Reset is asynchronous: CLK and RESET, RESET active-high and asynchronous.
- Address split:
  - tag = PC[31:3+IDX]
  - index = PC[3+IDX-1:3]
  - offset = PC[2]
- Storage per line: valid bit, tag, two 32-bit data words (hi = offset 0, lo = offset 4).
- Reset (asserted at any time, including mid-refill):
  - All valid bits cleared; state = LOOKUP; counters = 0.
  - Access_MM=0, PC_MM=0, Stall=0, Inst=0.
  - An in-flight refill is discarded and no line is written.
- FSM states: LOOKUP, FETCH, FILL.
- LOOKUP:
  - Req=0: Inst=0, Stall=0, no state or counter change.
  - Req=1 and hit (valid && tag match): Inst = offset ? lo : hi, combinationally in the same cycle. Stall=0; Hit_Count++ at the clock edge.
  - Req=1 and miss: Stall=1, Inst=0. At the edge, latch miss_pc=PC, clear the latency counter, Miss_Count++, go to FETCH.
- FETCH:
  - Access_MM=1, PC_MM={miss_pc[31:3],3'b000}, Stall=1, Inst=0.
  - The counter increments each cycle.
  - At the edge where counter==MISS_LATENCY-1: write Data_MM into line[miss_pc index], set valid=1 and tag=miss_pc tag, go to FILL.
- FILL:
  - Access_MM=0, Stall=1, Inst=0; go to LOOKUP next cycle.
- Miss timing:
  - Miss detected at cycle t. FETCH occupies t+1..t+MISS_LATENCY, FILL occupies t+MISS_LATENCY+1.
  - Replayed hit arrives at t+MISS_LATENCY+2, so Stall is high for MISS_LATENCY+2 cycles.
- The replayed lookup uses the current PC, not miss_pc. If upstream changed PC during the stall, the new PC is looked up and may miss again.
- Req and PC are ignored outside LOOKUP.
- Replacement: a refill overwrites the indexed line unconditionally (conflict eviction). The cache is read-only, with no write or invalidate port.
- Counters wrap modulo 2^32. Each replayed access after a refill counts as a hit, so one miss yields Miss_Count+1 and Hit_Count+1.
- Data_MM is sampled only at the final FETCH edge; its value at other times has no effect.

Test Plan:
1. Reset, then Req=1, PC=0x0 with mem[0]=0xA, mem[1]=0xB:
   - Stall high 6 cycles; Access_MM high 4 cycles with PC_MM=0x0.
   - Then Inst=0xA, Stall=0; Miss_Count=1, Hit_Count=1.
2. Following scenario 1, PC=0x4:
   - Hit in the same cycle: Inst=0xB, Stall=0, Access_MM=0; Hit_Count=2, Miss_Count unchanged.
3. Conflict: PC=0x0 (fill), then PC=0x40 (same index 0, NUM_LINES=8), then PC=0x0 again:
   - Three misses; PC_MM=0x40 then 0x0 on refills; Miss_Count=3.
4. RESET pulsed during the 2nd FETCH cycle of a PC=0x0 miss:
   - Access_MM and Stall drop immediately; Miss_Count=0.
   - A subsequent PC=0x0 misses again, with no stale valid line.
5. Miss on PC=0x0, with PC changed to 0x8 during the stall:
   - Block 0 is filled (PC_MM=0x0).
   - The replay at 0x8 misses and refills with PC_MM=0x8; afterwards PC=0x0 hits.
6. Req=0 for 10 cycles after warm-up:
   - Inst=0, Stall=0, Access_MM=0; counters unchanged; valid state preserved (next PC=0x0 hits).
